irt_dep_tracker: RTL and testbench
==================================

Name: irt_dep_tracker

Overview:
- Parametrised instruction dependency tracker for the ESM out-of-order buffer.
- Holds up to BS in-flight instructions in a circular buffer with NSRC sources each.
- Keeps a per-entry dependency matrix against older live entries (RAW, WAR, WAW) and clears dependencies on completion.
- Publishes a ready vector to the issue selector and retires entries in program order.

Parameters:
- BS, 32, buffer depth; power of two, 4..64.
- REGNUM, 16, architectural register count; x0 is hard-wired zero and never creates a dependency.
- NSRC, 2, source operands per instruction, 1..3.

Ports:
- clk  in  1  clock
- rst  in  1  reset; rst asynchronous, active-high; clock clk.
- alloc_valid  in  1  new instruction presented
- alloc_ready  out  1  not full; allocation occurs on alloc_valid && alloc_ready at posedge
- alloc_rd  in  log2(REGNUM)  destination register
- alloc_rs  in  NSRC*log2(REGNUM)  sources; source k occupies bits [k*W +: W]
- alloc_idx  out  log2(BS)  slot the next allocation will take (the tail pointer)
- issue_valid  in  1  issue selector dispatches issue_idx
- issue_idx  in  log2(BS)  slot being issued
- complete_valid  in  1  execution unit reports completion
- complete_idx  in  log2(BS)  slot completing
- ready_vec  out  BS  bit i = slot i is issuable
- count  out  log2(BS)+1  occupied slots
- full  out  1  count==BS
- empty  out  1  count==0
- err  out  1  sticky illegal-operation flag

Behaviour:
- Per-slot state: FREE, WAIT, ISSUED, DONE. Per-slot stored fields:
  - rd one-hot mask (zero if rd==0)
  - rs mask (OR of one-hot of nonzero sources)
  - dep row of BS bits
- Reset (async): all slots FREE, dep rows 0, head=tail=0, count=0, err=0. Outputs then read empty=1, full=0, alloc_ready=1, alloc_idx=0, ready_vec=0.
- Allocation at posedge when alloc_valid && !full:
  - slot tail becomes WAIT; tail increments modulo BS.
  - dep[tail][j]=1 for every slot j in WAIT/ISSUED (not DONE, not FREE) where any of the following holds:
    - RAW: rd_j & rs_new is nonzero
    - WAR: rs_j & rd_new is nonzero
    - WAW: rd_j & rd_new is nonzero
  - A slot never depends on itself.
  - alloc_valid while full: no change, err set.
- Issue at posedge when issue_valid: slot issue_idx must be WAIT with an all-zero dep row, and goes to ISSUED. Otherwise the issue is ignored and err is set.
- Completion at posedge when complete_valid: slot complete_idx must be ISSUED, and goes to DONE. Column complete_idx is cleared in every dep row in the same edge. A completion on a non-ISSUED slot is ignored and err is set.
- Same-edge completion of j and allocation: the new entry does not record a dependency on j.
- Same-edge issue and completion of the same slot: the issue is ignored and err is set; the completion is also illegal (slot not yet ISSUED).
- Retire: if slot head is DONE, at the next posedge it becomes FREE, its row clears, and head increments modulo BS. Maximum one retire per cycle, in order only.
- count = count + alloc − retire, both evaluated in the same cycle. alloc_ready, full and empty derive from the registered count, so a retire does not free space for an allocation in the same cycle.
- ready_vec[i] = (state_i==WAIT) && (dep row i == 0). Purely combinational from registers, with zero-cycle latency after the edge.
- Wrap-around: head and tail wrap independently. full is decided by count, not by pointer equality.
- rst mid-operation flushes every entry immediately, regardless of in-flight issue or complete inputs.

Test Plan:
- Reset then allocate A(rd=1, rs=2,3) and B(rd=4, rs=1,0) -> alloc_idx 0 then 1; ready_vec = 0b..01 (B has RAW on A); complete A after issue -> ready_vec bit1 = 1 next cycle.
- WAR/WAW: A(rd=5, rs=6), B(rd=6, rs=7), C(rd=5, rs=0) -> B depends on A (WAR), C depends on A (WAW); x0 source creates no dependency.
- Fill BS=4 with independent instructions -> full=1, alloc_ready=0; extra alloc_valid -> err=1, count stays 4; issue+complete slot 0 -> retire next cycle, count=3, alloc_idx wraps to 0.
- Same-edge: complete slot 0 (rd=3) while allocating D(rs=3) -> D's dep row is 0 and D is immediately ready.
- Out-of-order completion: complete slot 1 before slot 0 -> slot 1 DONE but no retire until slot 0 is DONE; then two retires on consecutive cycles.
- Assert rst with 3 entries live and issue_valid high -> outputs return to reset values asynchronously; err=0.

Source files
------------

// File: rtl/irt_dep_tracker.sv
// Dependency tracker for the ESM out-of-order buffer: circular slot buffer
// with a per-slot RAW/WAR/WAW matrix, ready vector and in-order retire.
module irt_dep_tracker #(
   parameter int BS     = 32,
   parameter int REGNUM = 16,
   parameter int NSRC   = 2
) (
   input  logic                             clk,
   input  logic                             rst,
   input  logic                             alloc_valid,
   output logic                             alloc_ready,
   input  logic [$clog2(REGNUM)-1:0]        alloc_rd,
   input  logic [NSRC*$clog2(REGNUM)-1:0]   alloc_rs,
   output logic [$clog2(BS)-1:0]            alloc_idx,
   input  logic                             issue_valid,
   input  logic [$clog2(BS)-1:0]            issue_idx,
   input  logic                             complete_valid,
   input  logic [$clog2(BS)-1:0]            complete_idx,
   output logic [BS-1:0]                    ready_vec,
   output logic [$clog2(BS):0]              count,
   output logic                             full,
   output logic                             empty,
   output logic                             err
);

   localparam int W  = $clog2(REGNUM);
   localparam int IW = $clog2(BS);

   typedef enum logic [1:0] {
      S_FREE,
      S_WAIT,
      S_ISSUED,
      S_DONE
   } st_t;

   st_t               st_q  [BS];
   st_t               st_n  [BS];
   logic [BS-1:0]     dep_q [BS];
   logic [BS-1:0]     dep_n [BS];
   logic [REGNUM-1:0] rdm_q [BS];
   logic [REGNUM-1:0] rdm_n [BS];
   logic [REGNUM-1:0] rsm_q [BS];
   logic [REGNUM-1:0] rsm_n [BS];

   logic [IW-1:0]     head_q, head_n;
   logic [IW-1:0]     tail_q, tail_n;
   logic [IW:0]       cnt_q, cnt_n;
   logic              err_q, err_n;

   logic              do_alloc;
   logic              issue_ok;
   logic              comp_ok;
   logic              retire;
   logic [REGNUM-1:0] new_rd;
   logic [REGNUM-1:0] new_rs;
   logic [BS-1:0]     new_row;

   // x0 maps to an empty mask so it can never create a hazard
   function automatic logic [REGNUM-1:0] onehot(input logic [W-1:0] r);
      logic [REGNUM-1:0] m;
      m = '0;
      if (r != '0) m[r] = 1'b1;
      return m;
   endfunction

   assign full        = (cnt_q == (IW+1)'(BS));
   assign empty       = (cnt_q == '0);
   assign alloc_ready = !full;
   assign alloc_idx   = tail_q;
   assign count       = cnt_q;
   assign err         = err_q;

   assign do_alloc = alloc_valid && !full;
   assign comp_ok  = complete_valid
                  && (st_q[complete_idx] == S_ISSUED);
   assign issue_ok = issue_valid
                  && (st_q[issue_idx] == S_WAIT)
                  && (dep_q[issue_idx] == '0)
                  && !(complete_valid
                       && (complete_idx == issue_idx));
   assign retire   = (st_q[head_q] == S_DONE);

   always_comb begin
      new_rd = onehot(alloc_rd);
      new_rs = '0;
      for (int k = 0; k < NSRC; k++)
         new_rs = new_rs | onehot(alloc_rs[k*W +: W]);
   end

   // a producer completing on this edge is already resolved for the newcomer
   always_comb begin
      new_row = '0;
      for (int j = 0; j < BS; j++) begin
         new_row[j] = ((st_q[j] == S_WAIT) || (st_q[j] == S_ISSUED))
                   && !(comp_ok && (complete_idx == IW'(j)))
                   && (IW'(j) != tail_q)
                   && ((|(rdm_q[j] & new_rs))
                    || (|(rsm_q[j] & new_rd))
                    || (|(rdm_q[j] & new_rd)));
      end
   end

   always_comb begin
      for (int i = 0; i < BS; i++)
         ready_vec[i] = (st_q[i] == S_WAIT) && (dep_q[i] == '0);
   end

   always_comb begin
      st_n   = st_q;
      dep_n  = dep_q;
      rdm_n  = rdm_q;
      rsm_n  = rsm_q;
      head_n = head_q;
      tail_n = tail_q;
      cnt_n  = cnt_q + (IW+1)'(do_alloc) - (IW+1)'(retire);
      err_n  = err_q
            | (alloc_valid && full)
            | (issue_valid && !issue_ok)
            | (complete_valid && !comp_ok);

      if (comp_ok) begin
         st_n[complete_idx] = S_DONE;
         for (int i = 0; i < BS; i++)
            dep_n[i][complete_idx] = 1'b0;
      end

      if (issue_ok)
         st_n[issue_idx] = S_ISSUED;

      if (retire) begin
         st_n[head_q]  = S_FREE;
         dep_n[head_q] = '0;
         head_n        = head_q + IW'(1);
      end

      if (do_alloc) begin
         st_n[tail_q]  = S_WAIT;
         dep_n[tail_q] = new_row;
         rdm_n[tail_q] = new_rd;
         rsm_n[tail_q] = new_rs;
         tail_n        = tail_q + IW'(1);
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int i = 0; i < BS; i++) begin
            st_q[i]  <= S_FREE;
            dep_q[i] <= '0;
            rdm_q[i] <= '0;
            rsm_q[i] <= '0;
         end
         head_q <= '0;
         tail_q <= '0;
         cnt_q  <= '0;
         err_q  <= 1'b0;
      end else begin
         st_q   <= st_n;
         dep_q  <= dep_n;
         rdm_q  <= rdm_n;
         rsm_q  <= rsm_n;
         head_q <= head_n;
         tail_q <= tail_n;
         cnt_q  <= cnt_n;
         err_q  <= err_n;
      end
   end

endmodule

// File: tb/tb_irt_dep_tracker.sv
// Directed bench for irt_dep_tracker with a 4-deep buffer.
module tb_irt_dep_tracker;

   logic       clk;
   logic       rst;
   logic       alloc_valid;
   logic       alloc_ready;
   logic [3:0] alloc_rd;
   logic [7:0] alloc_rs;
   logic [1:0] alloc_idx;
   logic       issue_valid;
   logic [1:0] issue_idx;
   logic       complete_valid;
   logic [1:0] complete_idx;
   logic [3:0] ready_vec;
   logic [2:0] count;
   logic       full;
   logic       empty;
   logic       err;

   int n_chk;
   int n_fail;

   irt_dep_tracker #(.BS(4), .REGNUM(16), .NSRC(2)) dut (
      .clk(clk), .rst(rst),
      .alloc_valid(alloc_valid), .alloc_ready(alloc_ready),
      .alloc_rd(alloc_rd), .alloc_rs(alloc_rs),
      .alloc_idx(alloc_idx),
      .issue_valid(issue_valid), .issue_idx(issue_idx),
      .complete_valid(complete_valid),
      .complete_idx(complete_idx),
      .ready_vec(ready_vec), .count(count),
      .full(full), .empty(empty), .err(err)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic idle();
      alloc_valid    = 1'b0;
      alloc_rd       = '0;
      alloc_rs       = '0;
      issue_valid    = 1'b0;
      issue_idx      = '0;
      complete_valid = 1'b0;
      complete_idx   = '0;
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      idle();
      rst = 1'b1;
      tick();
      rst = 1'b0;
   endtask

   task automatic alloc(input logic [3:0] rd,
                        input logic [3:0] s0,
                        input logic [3:0] s1);
      alloc_valid = 1'b1;
      alloc_rd    = rd;
      alloc_rs    = {s1, s0};
      tick();
      idle();
   endtask

   task automatic issue(input logic [1:0] idx);
      issue_valid = 1'b1;
      issue_idx   = idx;
      tick();
      idle();
   endtask

   task automatic complete(input logic [1:0] idx);
      complete_valid = 1'b1;
      complete_idx   = idx;
      tick();
      idle();
   endtask

   task automatic test_reset();
      do_reset();
      n_chk++;
      if ({empty, full, alloc_ready, err} !== 4'b1010) begin
         n_fail++;
         $display("FAIL reset_flags: got e/f/r/err=%b want 1010",
                  {empty, full, alloc_ready, err});
      end
      n_chk++;
      if ({alloc_idx, ready_vec, count} !== 9'd0) begin
         n_fail++;
         $display("FAIL reset_vals: idx=%0d rv=%b cnt=%0d want 0",
                  alloc_idx, ready_vec, count);
      end
   endtask

   task automatic test_raw();
      do_reset();
      alloc(4'd1, 4'd2, 4'd3);
      n_chk++;
      if (alloc_idx !== 2'd1) begin
         n_fail++;
         $display("FAIL raw_idx: got %0d want 1", alloc_idx);
      end
      alloc(4'd4, 4'd1, 4'd0);
      n_chk++;
      if (ready_vec !== 4'b0001) begin
         n_fail++;
         $display("FAIL raw_ready: got %b want 0001", ready_vec);
      end
      issue(2'd0);
      n_chk++;
      if (ready_vec !== 4'b0000) begin
         n_fail++;
         $display("FAIL raw_issued: got %b want 0000", ready_vec);
      end
      complete(2'd0);
      n_chk++;
      if (ready_vec !== 4'b0010) begin
         n_fail++;
         $display("FAIL raw_wake: got %b want 0010", ready_vec);
      end
      n_chk++;
      if (count !== 3'd2) begin
         n_fail++;
         $display("FAIL raw_cnt_done: got %0d want 2", count);
      end
      tick();
      n_chk++;
      if (count !== 3'd1 || err !== 1'b0) begin
         n_fail++;
         $display("FAIL raw_retire: cnt=%0d err=%b want 1 0",
                  count, err);
      end
   endtask

   task automatic test_war_waw();
      do_reset();
      alloc(4'd5, 4'd6, 4'd0);
      alloc(4'd6, 4'd7, 4'd0);
      alloc(4'd5, 4'd0, 4'd0);
      n_chk++;
      if (ready_vec !== 4'b0001) begin
         n_fail++;
         $display("FAIL ww_ready: got %b want 0001", ready_vec);
      end
      issue(2'd0);
      complete(2'd0);
      n_chk++;
      if (ready_vec !== 4'b0110) begin
         n_fail++;
         $display("FAIL ww_wake: got %b want 0110", ready_vec);
      end
      alloc(4'd0, 4'd0, 4'd0);
      n_chk++;
      if (ready_vec !== 4'b1110) begin
         n_fail++;
         $display("FAIL ww_x0: got %b want 1110", ready_vec);
      end
      n_chk++;
      if (count !== 3'd3 || err !== 1'b0) begin
         n_fail++;
         $display("FAIL ww_cnt: cnt=%0d err=%b want 3 0",
                  count, err);
      end
   endtask

   task automatic test_full();
      do_reset();
      for (int i = 1; i <= 4; i++)
         alloc(4'(i), 4'd0, 4'd0);
      n_chk++;
      if ({full, alloc_ready, empty} !== 3'b100) begin
         n_fail++;
         $display("FAIL full_flags: got f/r/e=%b want 100",
                  {full, alloc_ready, empty});
      end
      n_chk++;
      if (count !== 3'd4 || alloc_idx !== 2'd0) begin
         n_fail++;
         $display("FAIL full_cnt: cnt=%0d idx=%0d want 4 0",
                  count, alloc_idx);
      end
      n_chk++;
      if (ready_vec !== 4'b1111 || err !== 1'b0) begin
         n_fail++;
         $display("FAIL full_ready: rv=%b err=%b want 1111 0",
                  ready_vec, err);
      end
      alloc(4'd5, 4'd0, 4'd0);
      n_chk++;
      if (err !== 1'b1 || count !== 3'd4) begin
         n_fail++;
         $display("FAIL full_ovf: err=%b cnt=%0d want 1 4",
                  err, count);
      end
      issue(2'd0);
      complete(2'd0);
      n_chk++;
      if (count !== 3'd4) begin
         n_fail++;
         $display("FAIL full_done: got %0d want 4", count);
      end
      tick();
      n_chk++;
      if (count !== 3'd3 || full !== 1'b0 || alloc_idx !== 2'd0) begin
         n_fail++;
         $display("FAIL full_wrap: cnt=%0d full=%b idx=%0d want 3 0 0",
                  count, full, alloc_idx);
      end
   endtask

   task automatic test_same_edge();
      do_reset();
      alloc(4'd3, 4'd0, 4'd0);
      issue(2'd0);
      complete_valid = 1'b1;
      complete_idx   = 2'd0;
      alloc_valid    = 1'b1;
      alloc_rd       = 4'd5;
      alloc_rs       = {4'd0, 4'd3};
      tick();
      idle();
      n_chk++;
      if (ready_vec !== 4'b0010 || err !== 1'b0) begin
         n_fail++;
         $display("FAIL same_edge: rv=%b err=%b want 0010 0",
                  ready_vec, err);
      end
   endtask

   task automatic test_ooo();
      do_reset();
      alloc(4'd1, 4'd0, 4'd0);
      alloc(4'd2, 4'd0, 4'd0);
      alloc(4'd3, 4'd0, 4'd0);
      issue(2'd0);
      issue(2'd1);
      complete(2'd1);
      tick();
      n_chk++;
      if (count !== 3'd3 || ready_vec !== 4'b0100) begin
         n_fail++;
         $display("FAIL ooo_hold: cnt=%0d rv=%b want 3 0100",
                  count, ready_vec);
      end
      complete(2'd0);
      n_chk++;
      if (count !== 3'd3) begin
         n_fail++;
         $display("FAIL ooo_c0: got %0d want 3", count);
      end
      tick();
      n_chk++;
      if (count !== 3'd2) begin
         n_fail++;
         $display("FAIL ooo_r0: got %0d want 2", count);
      end
      tick();
      n_chk++;
      if (count !== 3'd1 || err !== 1'b0 || alloc_idx !== 2'd3) begin
         n_fail++;
         $display("FAIL ooo_r1: cnt=%0d err=%b idx=%0d want 1 0 3",
                  count, err, alloc_idx);
      end
   endtask

   task automatic test_issue_complete_clash();
      do_reset();
      alloc(4'd1, 4'd0, 4'd0);
      issue_valid    = 1'b1;
      issue_idx      = 2'd0;
      complete_valid = 1'b1;
      complete_idx   = 2'd0;
      tick();
      idle();
      n_chk++;
      if (err !== 1'b1 || ready_vec !== 4'b0001) begin
         n_fail++;
         $display("FAIL clash: err=%b rv=%b want 1 0001",
                  err, ready_vec);
      end
   endtask

   task automatic test_async_reset();
      do_reset();
      alloc(4'd1, 4'd0, 4'd0);
      alloc(4'd2, 4'd1, 4'd0);
      alloc(4'd3, 4'd0, 4'd0);
      complete(2'd3);
      n_chk++;
      if (err !== 1'b1 || count !== 3'd3) begin
         n_fail++;
         $display("FAIL ar_pre: err=%b cnt=%0d want 1 3", err, count);
      end
      issue_valid = 1'b1;
      issue_idx   = 2'd0;
      #2;
      rst = 1'b1;
      #1;
      n_chk++;
      if ({empty, full, alloc_ready, err} !== 4'b1010) begin
         n_fail++;
         $display("FAIL ar_flags: got e/f/r/err=%b want 1010",
                  {empty, full, alloc_ready, err});
      end
      n_chk++;
      if ({alloc_idx, ready_vec, count} !== 9'd0) begin
         n_fail++;
         $display("FAIL ar_vals: idx=%0d rv=%b cnt=%0d want 0",
                  alloc_idx, ready_vec, count);
      end
      idle();
      tick();
      rst = 1'b0;
   endtask

   initial begin
      n_chk  = 0;
      n_fail = 0;
      rst    = 1'b1;
      idle();
      test_reset();
      test_raw();
      test_war_waw();
      test_full();
      test_same_edge();
      test_ooo();
      test_issue_complete_clash();
      test_async_reset();
      $display("End of test - %0d assertions evaluated, %0d failures",
               n_chk, n_fail);
      $finish;
   end

endmodule
